// File: rtl/wb_pkg.sv
// Shared definitions for the writeback stage: load-type encodings and the
// hard-wired zero register index.
package wb_pkg;

   typedef enum logic [2:0] {
      LD_NONE = 3'd0,
      LB      = 3'd1,
      LBU     = 3'd2,
      LH      = 3'd3,
      LHU     = 3'd4,
      LW      = 3'd5
   } ld_type_e;

   localparam logic [4:0] R0 = 5'd0;

endpackage

// File: rtl/load_align.sv
// Combinational load extractor for the writeback stage.
// Ports:
//   ld_type_i    - load type (wb_pkg::ld_type_e encoding)
//   addr_lo_i    - byte address bits [1:0]
//   alu_i        - ALU result, selected for non-loads
//   mem_i        - raw little-endian memory word
//   data_o       - extended load data or ALU result
//   misaligned_o - halfword/word access not on its natural boundary
module load_align
   import wb_pkg::*;
(
   input  logic [2:0]  ld_type_i,
   input  logic [1:0]  addr_lo_i,
   input  logic [31:0] alu_i,
   input  logic [31:0] mem_i,
   output logic [31:0] data_o,
   output logic        misaligned_o
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   always_comb begin
      unique case (addr_lo_i)
         2'd0:    byte_sel = mem_i[7:0];
         2'd1:    byte_sel = mem_i[15:8];
         2'd2:    byte_sel = mem_i[23:16];
         default: byte_sel = mem_i[31:24];
      endcase
      // Halfword select ignores addr_lo[0]; misalignment is flagged separately.
      half_sel = addr_lo_i[1] ? mem_i[31:16] : mem_i[15:0];
   end

   always_comb begin
      data_o       = alu_i;
      misaligned_o = 1'b0;
      case (ld_type_i)
         LB:  data_o = {{24{byte_sel[7]}}, byte_sel};
         LBU: data_o = {24'd0, byte_sel};
         LH: begin
            data_o       = {{16{half_sel[15]}}, half_sel};
            misaligned_o = addr_lo_i[0];
         end
         LHU: begin
            data_o       = {16'd0, half_sel};
            misaligned_o = addr_lo_i[0];
         end
         LW: begin
            data_o       = mem_i;
            misaligned_o = (addr_lo_i != 2'd0);
         end
         // LD_NONE and unused encodings pass the ALU result.
         default: data_o = alu_i;
      endcase
   end

endmodule

// File: rtl/writeback_stage.sv
// MEM/WB pipeline stage: latches the instruction leaving memory, extracts
// load data, drives the register file write port, bypasses the pending write
// to decode, counts retired instructions and flags misaligned loads.
// Ports:
//   Clk, Clr             - clock, asynchronous active-high reset
//   m_*                  - instruction presented by the memory stage
//   stall, flush         - hold the WB register / load a bubble
//   err_clr              - clear the sticky misalign flag
//   RD, dataRD, RW       - register file write port
//   RS, RT, rf_RS, rf_RT - decode read selects and raw register file data
//   byp_RS, byp_RT       - bypassed read data for decode
//   retired              - retired-instruction count
//   err_misalign         - sticky misaligned-load flag
module writeback_stage
   import wb_pkg::*;
#(
   parameter int unsigned CNT_W = 32
) (
   input  logic             Clk,
   input  logic             Clr,
   input  logic             m_valid,
   input  logic [4:0]       m_rd,
   input  logic             m_reg_write,
   input  logic [2:0]       m_ld_type,
   input  logic [1:0]       m_addr_lo,
   input  logic [31:0]      m_alu,
   input  logic [31:0]      m_mem,
   input  logic             stall,
   input  logic             flush,
   input  logic             err_clr,
   output logic [4:0]       RD,
   output logic [31:0]      dataRD,
   output logic             RW,
   input  logic [4:0]       RS,
   input  logic [4:0]       RT,
   input  logic [31:0]      rf_RS,
   input  logic [31:0]      rf_RT,
   output logic [31:0]      byp_RS,
   output logic [31:0]      byp_RT,
   output logic [CNT_W-1:0] retired,
   output logic             err_misalign
);

   logic             valid_q, valid_d;
   logic [4:0]       rd_q, rd_d;
   logic             reg_write_q, reg_write_d;
   logic [2:0]       ld_type_q, ld_type_d;
   logic [1:0]       addr_lo_q, addr_lo_d;
   logic [31:0]      alu_q, alu_d;
   logic [31:0]      mem_q, mem_d;
   logic [CNT_W-1:0] retired_q, retired_d;
   logic             err_q, err_d;

   logic [31:0] ext_data;
   logic        misaligned;
   logic        retire;

   load_align u_load_align (
      .ld_type_i    (ld_type_q),
      .addr_lo_i    (addr_lo_q),
      .alu_i        (alu_q),
      .mem_i        (mem_q),
      .data_o       (ext_data),
      .misaligned_o (misaligned)
   );

   // WB register next state: flush beats stall.
   always_comb begin
      valid_d     = valid_q;
      rd_d        = rd_q;
      reg_write_d = reg_write_q;
      ld_type_d   = ld_type_q;
      addr_lo_d   = addr_lo_q;
      alu_d       = alu_q;
      mem_d       = mem_q;
      if (flush) begin
         valid_d = 1'b0;
      end else if (!stall) begin
         valid_d     = m_valid;
         rd_d        = m_rd;
         reg_write_d = m_reg_write;
         ld_type_d   = m_ld_type;
         addr_lo_d   = m_addr_lo;
         alu_d       = m_alu;
         mem_d       = m_mem;
      end
   end

   assign retire = valid_q & ~stall;

   always_comb begin
      retired_d = retired_q + CNT_W'(retire);
      err_d     = err_q;
      // A new misaligned retirement wins over a same-edge clear.
      if (retire && misaligned) begin
         err_d = 1'b1;
      end else if (err_clr) begin
         err_d = 1'b0;
      end
   end

   // All fields reset so RD/dataRD read zero while in reset.
   always_ff @(posedge Clk or posedge Clr) begin
      if (Clr) begin
         valid_q     <= 1'b0;
         rd_q        <= R0;
         reg_write_q <= 1'b0;
         ld_type_q   <= LD_NONE;
         addr_lo_q   <= 2'd0;
         alu_q       <= 32'd0;
         mem_q       <= 32'd0;
         retired_q   <= '0;
         err_q       <= 1'b0;
      end else begin
         valid_q     <= valid_d;
         rd_q        <= rd_d;
         reg_write_q <= reg_write_d;
         ld_type_q   <= ld_type_d;
         addr_lo_q   <= addr_lo_d;
         alu_q       <= alu_d;
         mem_q       <= mem_d;
         retired_q   <= retired_d;
         err_q       <= err_d;
      end
   end

   assign RD           = rd_q;
   assign dataRD       = ext_data;
   assign RW           = retire & reg_write_q & (rd_q != R0) & ~misaligned;
   assign byp_RS       = (RW && (RS == rd_q)) ? ext_data : rf_RS;
   assign byp_RT       = (RW && (RT == rd_q)) ? ext_data : rf_RT;
   assign retired      = retired_q;
   assign err_misalign = err_q;

endmodule

// File: doc/writeback_stage.md
# writeback_stage

Final (MEM/WB) pipeline stage of the 32-register processor datapath. Latches the instruction leaving the memory stage and extracts and sign/zero-extends load data. Selects between ALU result and load data, then drives the register file write port (RD, dataRD, RW). Also supplies same-cycle bypass data to the decode stage, maintains a retired-instruction counter and flags misaligned loads.

## Interface
Parameters:
- CNT_W, 32, width of retired-instruction counter

Ports:
- Clk  in  1  rising-edge clock
- Clr  in  1  asynchronous, active-high reset
- m_valid  in  1  memory stage presents an instruction
- m_rd  in  5  destination register
- m_reg_write  in  1  instruction writes a register
- m_ld_type  in  3  load type (NONE, LB, LBU, LH, LHU, LW)
- m_addr_lo  in  2  byte address bits [1:0] of the load
- m_alu  in  32  ALU result
- m_mem  in  32  raw memory word, little-endian
- stall  in  1  hold the WB register; the instruction does not retire
- flush  in  1  load a bubble instead of the m_* inputs
- err_clr  in  1  clear the sticky misalign flag
- RD  out  5  register file write select
- dataRD  out  32  register file write data
- RW  out  1  register file write enable (1 = write)
- RS, RT  in  5 each  decode-stage read selects
- rf_RS, rf_RT  in  32 each  raw register file read data
- byp_RS, byp_RT  out  32 each  bypassed read data
- retired  out  CNT_W  retired-instruction count
- err_misalign  out  1  sticky misaligned-load flag

## Operation
- WB register (valid, rd, reg_write, ld_type, addr_lo, alu, mem) updates on Clk rising edge:
  - Clr: valid=0.
  - Otherwise, flush: valid=0, regardless of stall.
  - Otherwise, stall: hold all fields.
  - Otherwise: capture m_*, with valid=m_valid.
- Load extract, with byte k = mem[8k+7:8k]:
  - LB: sign-extend byte[addr_lo]. LBU: zero-extend it.
  - LH: sign-extend halfword at addr_lo[1]. LHU: zero-extend it.
  - LW: whole word.
  - NONE: select alu.
- Misaligned load: LH/LHU with addr_lo[0]=1, or LW with addr_lo≠0.
- retire = valid & ~stall.
- RD = rd; dataRD = extract result.
- RW = retire & reg_write & (rd≠0) & ~misaligned. A write to R0 is never issued.
- Bypass:
  - byp_RS = dataRD when RW & (RS==RD), else rf_RS.
  - byp_RT follows the same rule with RT and rf_RT.
- retired increments by 1 on every edge where retire=1. Wraps modulo 2^CNT_W.
- err_misalign sets on an edge where retire & misaligned, and clears on err_clr. When both happen on the same edge, set wins.
- A misaligned instruction still retires and is counted.

## Timing
- Reset values: valid=0, RW=0, RD=0, dataRD=0, retired=0, err_misalign=0. byp_* equal rf_* while in reset.
- Latency: an instruction captured at edge N drives RW/dataRD during cycle N+1. The register file commits it at edge N+1 if stall=0.
- During stall, RW=0. The instruction retires on the first edge with stall=0 and is counted once.
- Clr asserted mid-operation discards the held instruction immediately, with no write.
- flush and stall in the same cycle: the held instruction does not retire, and the register becomes a bubble.
- Bypass is purely combinational within the cycle. Decode sees the value that will be written at the next edge.

## Structure
- Package wb_pkg:
  - LD_NONE=0, LB=1, LBU=2, LH=3, LHU=4, LW=5.
  - Constant R0=5'd0.
- Sub-module load_align: combinational extractor (ld_type, addr_lo, alu, mem → data, misaligned).
- Remaining logic (WB register, counter, flag, bypass) lives in writeback_stage.

## Test plan
- ALU write: m_rd=5, m_alu=0x1234_5678, NONE → RW=1, RD=5, dataRD=0x12345678 next cycle; retired=1.
- Loads with m_mem=0x80FF_7F01:
  - LB addr 3 → 0xFFFFFF80.
  - LBU addr 1 → 0x0000007F.
  - LH addr 2 → 0xFFFF80FF.
  - LHU addr 0 → 0x00007F01.
  - LW → 0x80FF7F01.
- Misaligned LW at addr 2 → RW=0, err_misalign=1 and held through a later valid instruction. err_clr together with a new misaligned load → stays 1.
- Write to R0 (m_rd=0, reg_write=1) → RW=0, retired still increments.
- Stall 3 cycles on a valid write → RW=0 for 3 cycles, then one write; retired +1 only. flush+stall together → no write, retired unchanged.
- Bypass: RW to R7 with 0xDEAD_BEEF and RS=7, rf_RS=0 → byp_RS=0xDEADBEEF. RT=8 → byp_RT=rf_RT. Clr asserted mid-cycle → RW drops to 0 immediately.
